// File: rtl/rd53_pkg.sv
// -----------------------------------------------------------------------------
// rd53_pkg
// Shared definitions for the rd53 weight enumerator.
//   state_e    : enumerator FSM states (IDLE / SCAN / HOLD)
//   MAX_WEIGHT : largest legal target popcount for a 5-bit word
//   LAST_WORD  : final word of each enumeration (k ones packed into the MSBs)
//   COUNT      : number of 5-bit words of each popcount, C(5,k)
// -----------------------------------------------------------------------------
package rd53_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int unsigned MAX_WEIGHT = 5;

    localparam logic [4:0] LAST_WORD [0:5] = '{
        5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111
    };

    localparam int unsigned COUNT [0:5] = '{1, 5, 10, 10, 5, 1};

endpackage

// File: rtl/rd53_popcnt.sv
// -----------------------------------------------------------------------------
// rd53_popcnt
// Combinational population count of a 5-bit word.
// Ports:
//   word_i : 5-bit word to count
//   cnt_o  : number of set bits in word_i (0..5)
// -----------------------------------------------------------------------------
module rd53_popcnt (
    input  logic [4:0] word_i,
    output logic [2:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < 5; i++) begin
            cnt_o = cnt_o + {2'b00, word_i[i]};
        end
    end

endmodule

// File: rtl/rd53_enum.sv
// -----------------------------------------------------------------------------
// rd53_enum
// Inverse of the rd53 weight function: for an accepted weight k, emits every
// 5-bit word whose popcount equals k, once each, in ascending numeric order.
// A candidate counter scans upward one value per cycle; each matching value is
// presented on a valid/ready output and held until the consumer accepts it.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   req_valid  : request strobe
//   req_ready  : high only while idle
//   req_weight : target popcount, legal 0..5
//   out_valid  : out_word is valid
//   out_ready  : consumer accepts out_word
//   out_word   : current word of the enumeration
//   out_last   : out_word is the final word of the enumeration
//   err        : one-cycle pulse when an illegal weight (>5) is requested
//   out_index  : ordinal of out_word within the enumeration
//
// Configuration:
//   RD53_ENUM_INDEX_EN : when defined, the out_index port and its counter exist.
// -----------------------------------------------------------------------------
module rd53_enum
    import rd53_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_weight,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_word,
    output logic       out_last,
    output logic       err
`ifdef RD53_ENUM_INDEX_EN
    ,
    output logic [3:0] out_index
`endif
);

    state_e     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [4:0] cand_q, cand_d;
    logic [4:0] word_q, word_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic       err_q, err_d;
    logic [2:0] cand_cnt;
`ifdef RD53_ENUM_INDEX_EN
    logic [3:0] idx_q, idx_d;
`endif

    rd53_popcnt u_popcnt (
        .word_i (cand_q),
        .cnt_o  (cand_cnt)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        k_d     = k_q;
        cand_d  = cand_q;
        word_d  = word_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = 1'b0;
`ifdef RD53_ENUM_INDEX_EN
        idx_d   = idx_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cand_d = '0;
`ifdef RD53_ENUM_INDEX_EN
                    idx_d  = '0;
`endif
                    if (req_weight > 3'(MAX_WEIGHT)) begin
                        err_d = 1'b1;
                    end else begin
                        // k is only latched when legal, so LAST_WORD is never indexed past 5.
                        k_d     = req_weight;
                        state_d = SCAN;
                    end
                end
            end

            SCAN: begin
                if (cand_cnt == k_q) begin
                    word_d  = cand_q;
                    valid_d = 1'b1;
                    last_d  = (cand_q == LAST_WORD[k_q]);
                    state_d = HOLD;
                end else begin
                    // The last word of every k is reached by 31, so this never wraps.
                    cand_d = cand_q + 5'd1;
                end
            end

            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
`ifdef RD53_ENUM_INDEX_EN
                    idx_d   = idx_q + 4'd1;
`endif
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        cand_d  = cand_q + 5'd1;
                        state_d = SCAN;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            cand_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef RD53_ENUM_INDEX_EN
            idx_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            k_q     <= k_d;
            cand_q  <= cand_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
`ifdef RD53_ENUM_INDEX_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign out_valid = valid_q;
    assign out_word  = word_q;
    assign out_last  = last_q;
    assign err       = err_q;
`ifdef RD53_ENUM_INDEX_EN
    assign out_index = idx_q;
`endif

endmodule

// File: tb/tb_rd53_enum.sv
// -----------------------------------------------------------------------------
// tb_rd53_enum
// Self-checking bench for rd53_enum. Expected words are generated from a
// brute-force popcount model and queued when a request is issued; a monitor
// pops and compares one entry per output handshake. Inputs change 1 time unit
// after the rising edge, outputs are sampled on the falling edge.
// Configuration: RD53_ENUM_INDEX_EN enables out_index checking.
// -----------------------------------------------------------------------------
module tb_rd53_enum;
    import rd53_pkg::*;

    typedef struct {
        logic [4:0] w;
        logic       last;
        logic [3:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_weight;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_word;
    logic       out_last;
    logic       err;
`ifdef RD53_ENUM_INDEX_EN
    logic [3:0] out_index;
`endif

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   hs_count = 0;
    bit   rand_bp  = 1'b0;

    rd53_enum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_weight (req_weight),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_last   (out_last),
        .err        (err)
`ifdef RD53_ENUM_INDEX_EN
        ,
        .out_index  (out_index)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: all 5-bit words of popcount k, ascending; the last is the largest.
    task automatic sb_push(input int k);
        exp_t e;
        int   last_w;
        int   n;
        last_w = -1;
        n      = 0;
        for (int w = 0; w < 32; w++)
            if ($countones(5'(w)) == k) last_w = w;
        for (int w = 0; w < 32; w++) begin
            if ($countones(5'(w)) == k) begin
                e.w    = 5'(w);
                e.last = (w == last_w);
                e.idx  = 4'(n);
                n++;
                sb.push_back(e);
            end
        end
    endtask

    // Monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
                check("unexpected_word", 32'(out_word), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("out_word", 32'(out_word), 32'(e.w));
                check("out_last", 32'(out_last), 32'(e.last));
`ifdef RD53_ENUM_INDEX_EN
                check("out_index", 32'(out_index), 32'(e.idx));
`endif
            end
        end
    end

    // Issue one legal request and return on the falling edge where the first word is valid.
    task automatic send(input int k, input bit chk_lat);
        int first_w;
        int lat;
        bit seen;
        first_w = -1;
        for (int w = 31; w >= 0; w--)
            if ($countones(5'(w)) == k) first_w = w;
        sb_push(k);
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_weight = 3'(k);
        @(negedge clk);
        check("req_ready_at_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = out_valid;
        end
        check("first_word_seen", 32'(seen), 32'd1);
        if (chk_lat) check("first_latency", 32'(lat), 32'(first_w + 1));
    endtask

    task automatic wait_idle(input int bound);
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        while (!done && n < bound) begin
            @(posedge clk); #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            n++;
            @(negedge clk);
            done = req_ready && !out_valid;
        end
        check("return_to_idle", 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_weight = '0;
        out_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_out_word",  32'(out_word),  32'd0);
`ifdef RD53_ENUM_INDEX_EN
        check("rst_out_index", 32'(out_index), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // k=2, consumer always ready
        out_ready = 1'b1;
        send(2, 1'b1);
        wait_idle(200);
        check("k2_req_ready_after", 32'(req_ready), 32'd1);

        // k=0 and k=5 single-word enumerations
        send(0, 1'b1);
        wait_idle(50);
        send(5, 1'b1);
        wait_idle(50);

        // k=3 with the first word stalled for three cycles
        out_ready = 1'b0;
        send(3, 1'b1);
        check("stall_word_0", 32'(out_word), 32'h07);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 2) out_ready = 1'b1;
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_word",  32'(out_word),  32'h07);
        end
        wait_idle(300);

        // Illegal weights
        for (int k = 6; k < 8; k++) begin
            @(posedge clk); #1;
            req_valid  = 1'b1;
            req_weight = 3'(k);
            @(negedge clk);
            check("bad_req_ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            check("bad_err_pulse", 32'(err),       32'd1);
            check("bad_no_valid",  32'(out_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("bad_err_clear", 32'(err),       32'd0);
            check("bad_ready_aft", 32'(req_ready), 32'd1);
            check("bad_no_valid2", 32'(out_valid), 32'd0);
        end

        // Reset while holding a k=3 word, then a fresh k=1 run
        out_ready = 1'b0;
        send(3, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("hold_rst_valid", 32'(out_valid), 32'd0);
        check("hold_rst_ready", 32'(req_ready), 32'd1);
        check("hold_rst_last",  32'(out_last),  32'd0);
        check("hold_rst_word",  32'(out_word),  32'd0);
        out_ready = 1'b1;
        send(1, 1'b1);
        wait_idle(100);

        // Request held across a busy period is taken on the first idle cycle
        out_ready = 1'b0;
        send(1, 1'b0);
        sb_push(2);
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_weight = 3'd2;
        @(negedge clk);
        check("busy_not_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        check("held_req_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle(200);

        // Every weight with random backpressure; word count must equal C(5,k)
        rand_bp = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            base = hs_count;
            send(k, 1'b1);
            wait_idle(600);
            check("word_count", 32'(hs_count - base), 32'(COUNT[k]));
        end
        rand_bp   = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rd53_enum.md
RD53_ENUM -- requirements
Module: rd53_enum

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: req_valid  in  1  request strobe.
REQ-004 SHALL have ports: req_ready  out  1  high only in IDLE.
REQ-005 SHALL have ports: req_weight  in  3  target popcount; legal range 0..5.
REQ-006 SHALL have ports: out_valid  out  1  out_word valid.
REQ-007 SHALL have ports: out_ready  in  1  consumer accept.
REQ-008 SHALL have ports: out_word  out  5  bits {v4,v3,v2,v1,v0} of a word whose popcount equals the weight.
REQ-009 SHALL have ports: out_last  out  1  final word of the enumeration.
REQ-010 SHALL have ports: err  out  1  one-cycle pulse on an illegal weight.
REQ-011 SHALL have ports: out_index  out  4  ordinal of out_word within the enumeration (RD53_ENUM_INDEX_EN only).

Function
REQ-012 SHALL be the inverse of the rd53 weight function: for each accepted weight k, emit every 5-bit word of popcount k exactly once, in ascending numeric order (C(5,k) words).
REQ-013 SHALL use FSM states IDLE, SCAN and HOLD.
REQ-014 SHALL accept a request when req_valid && req_ready; k is latched and cand is cleared to 0; next state is SCAN, or IDLE with err=1 for one cycle if k>5.
REQ-015 In SCAN, each cycle SHALL evaluate cand: on popcount(cand)==k, register out_word<=cand and out_valid<=1 and go to HOLD; otherwise cand<=cand+1 and stay in SCAN.
REQ-016 SHALL assert out_valid exactly c+1 cycles after acceptance for the first word, c = first matching cand (e.g. k=0 -> 1 cycle, k=2 -> 4 cycles).
REQ-017 In HOLD, out_word, out_last and out_index SHALL stay stable while out_valid && !out_ready.
REQ-018 On a HOLD handshake: if out_last, go to IDLE and clear out_valid; else cand<=cand+1, clear out_valid, go to SCAN.
REQ-019 SHALL drive out_last=1 iff out_word == LAST_WORD[k], where LAST_WORD = k ones in the MSBs (k=0 -> 00000, k=2 -> 11000, k=5 -> 11111).
REQ-020 cand SHALL never wrap: for k=5 the enumeration ends at 11111 before any increment past 31.
REQ-021 SHALL ignore req_valid outside IDLE; a request held across a busy period SHALL be accepted on the first IDLE cycle.

Reset
REQ-022 With rst_n=0 at a clock edge, state SHALL be IDLE and out_valid, out_last, err, cand, out_word and out_index SHALL all be 0.
REQ-023 Reset in SCAN or HOLD SHALL abort the enumeration with no further words, and req_ready SHALL be 1 on the first cycle after rst_n returns high.

Configuration
REQ-024 Macro RD53_ENUM_INDEX_EN defined: out_index is present, 0 for the first word of each enumeration, incremented on each out handshake, cleared on acceptance.
REQ-025 Macro RD53_ENUM_INDEX_EN undefined: out_index and its counter are absent, and all other behaviour is identical.

Structure
REQ-026 SHALL take from shared package rd53_pkg: the state enum (IDLE/SCAN/HOLD), the constant MAX_WEIGHT=5, the LAST_WORD[0:5] table and the COUNT[0:5]={1,5,10,10,5,1} table.
REQ-027 SHALL instantiate one sub-module rd53_popcnt (5-bit combinational popcount, 3-bit result) for the SCAN match compare.

Verification
REQ-028 Bench: k=2, out_ready=1 -> words 00011,00101,00110,01001,01010,01100,10001,10010,10100,11000; out_last only on 11000; then req_ready=1.
REQ-029 Bench: k=0 -> single word 00000 with out_last=1, out_valid one cycle after acceptance; k=5 -> single word 11111 with out_last=1.
REQ-030 Bench: k=3 with out_ready held low for 3 cycles on word 00111 -> word stable for 4 cycles, and the next word 01011 follows.
REQ-031 Bench: k=6 -> err=1 for exactly one cycle, no out_valid, req_ready=1 the following cycle.
REQ-032 Bench: rst_n low in HOLD during a k=3 run -> out_valid=0 immediately after, then a new k=1 request yields 00001,00010,00100,01000,10000.
REQ-033 Bench with RD53_ENUM_INDEX_EN: k=4 -> out_index 0..4 paired with 01111,10111,11011,11101,11110; the emitted word count equals COUNT[k] for every k in 0..5.
